// File: rtl/encrypt_sched.sv
// encrypt_sched -- two-requester packet scheduler in front of a fixed-latency
// encryption pipeline, with credit-based flow control into a result FIFO.
//
// Two requesters offer 65-bit beats (bit 64 = last-of-packet). A round-robin
// arbiter in IDLE grants one channel, which then owns the pipeline until its
// last beat is accepted, so packets never interleave. Each accepted beat is
// issued one cycle later on compute_resq/clr_data/key. The key is a snapshot
// of the channel key register taken at the packet's first beat.
//
// Pipeline latency: compute_resq counts as the first of the PIPE_LAT cycles,
// so a result arrives on encrypt_data_valid PIPE_LAT-1 cycles after the
// compute_resq cycle. The channel tag rides alongside in a PIPE_LAT-stage
// shift register whose stage 0 is loaded in parallel with compute_resq. A
// result reaches out_valid PIPE_LAT+1 cycles after the beat was accepted.
//
// Credits start at FIFO_DEPTH. Each issue takes one and each FIFO pop returns
// one, so in-flight beats plus FIFO occupancy can never exceed FIFO_DEPTH and
// the FIFO push never needs a full check.
//
// Parameters: PIPE_LAT (pipeline latency), FIFO_DEPTH (power of two, >= 2,
//             >= PIPE_LAT).
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   in{0,1}_valid/data/ready     requester beat streams
//   key_wr, key_sel, key_wdata   per-channel key register write
//   compute_resq, clr_data, key  issue to the encryption pipeline
//   encrypt_data(_valid)         result from the encryption pipeline
//   out_valid/data/ch/ready      result stream (first-word fall-through)
// Optional build macro ENC_SCHED_STATS_EN adds stat_pkt0, stat_pkt1 and
// stat_stall counters (32-bit, wrapping).

module encrypt_sched #(
  parameter int PIPE_LAT   = 5,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in0_valid,
  input  logic [64:0] in0_data,
  output logic        in0_ready,
  input  logic        in1_valid,
  input  logic [64:0] in1_data,
  output logic        in1_ready,
  input  logic        key_wr,
  input  logic        key_sel,
  input  logic [63:0] key_wdata,
  output logic        compute_resq,
  output logic [64:0] clr_data,
  output logic [63:0] key,
  input  logic [64:0] encrypt_data,
  input  logic        encrypt_data_valid,
  output logic        out_valid,
  output logic [64:0] out_data,
  output logic        out_ch,
  input  logic        out_ready
`ifdef ENC_SCHED_STATS_EN
  ,
  output logic [31:0] stat_pkt0,
  output logic [31:0] stat_pkt1,
  output logic [31:0] stat_stall
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DISC_W = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic   rr_reg, rr_next;          // channel favoured at the next contended grant
  logic   first_reg, first_next;    // next accepted beat is the packet's first
  logic   grant_ch;

  logic [CNT_W-1:0] credit_reg;
  logic             credit_ok;

  // Channel-indexed views of the two requester ports
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [64:0] in_data [2];

  logic        cur_ch;
  logic        acc;
  logic [64:0] acc_data;

  logic [63:0] key_regs [2];
  logic [63:0] pkt_key_reg;

  logic        compute_resq_reg;
  logic [64:0] clr_data_reg;
  logic [63:0] key_reg;

  logic [PIPE_LAT-1:0] tag_pipe_reg;
  logic [DISC_W-1:0]   disc_reg;

  logic [65:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_reg, rd_ptr_reg;
  logic             push, pop;

  assign in_valid[0] = in0_valid;
  assign in_valid[1] = in1_valid;
  assign in_data[0]  = in0_data;
  assign in_data[1]  = in1_data;
  assign in0_ready   = in_ready[0];
  assign in1_ready   = in_ready[1];

  assign cur_ch    = (state_reg == BUSY1);
  assign credit_ok = (credit_reg != '0);

  // Ready comes from registered state; only the credit term is combinational
  assign in_ready[0] = (state_reg == BUSY0) && credit_ok;
  assign in_ready[1] = (state_reg == BUSY1) && credit_ok;

  assign acc      = in_valid[cur_ch] && in_ready[cur_ch];
  assign acc_data = in_data[cur_ch];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      rr_reg    <= 1'b0;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      rr_reg    <= rr_next;
      first_reg <= first_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rr_next    = rr_reg;
    first_next = first_reg;
    grant_ch   = 1'b0;
    case (state_reg)
      IDLE: begin
        // With no credit the grant waits, so the FSM holds in IDLE
        if (credit_ok && (in_valid != 2'b00)) begin
          grant_ch   = (in_valid == 2'b11) ? rr_reg : in_valid[1];
          state_next = grant_ch ? BUSY1 : BUSY0;
          rr_next    = ~grant_ch;
          first_next = 1'b1;
        end
      end
      BUSY0, BUSY1: begin
        if (acc) begin
          first_next = 1'b0;
          if (acc_data[64]) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- keys
  // A write lands at the clock edge, so a snapshot taken on that same edge
  // still sees the previous value.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      always_ff @(posedge clk) begin
        if (reset) begin
          key_regs[gi] <= '0;
        end else if (key_wr && (key_sel == 1'(gi))) begin
          key_regs[gi] <= key_wdata;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- issue
  always_ff @(posedge clk) begin
    if (reset) begin
      compute_resq_reg <= 1'b0;
      clr_data_reg     <= '0;
      key_reg          <= '0;
      pkt_key_reg      <= '0;
    end else begin
      compute_resq_reg <= acc;
      if (acc) begin
        clr_data_reg <= acc_data;
        if (first_reg) begin
          key_reg     <= key_regs[cur_ch];
          pkt_key_reg <= key_regs[cur_ch];
        end else begin
          key_reg <= pkt_key_reg;
        end
      end
    end
  end

  assign compute_resq = compute_resq_reg;
  assign clr_data     = clr_data_reg;
  assign key          = key_reg;

  // ---------------------------------------------------------------- tag pipe
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_pipe_reg[0] <= 1'b0;
    end else begin
      tag_pipe_reg[0] <= acc && cur_ch;
    end
  end

  generate
    for (gi = 1; gi < PIPE_LAT; gi++) begin : g_tag
      always_ff @(posedge clk) begin
        if (reset) begin
          tag_pipe_reg[gi] <= 1'b0;
        end else begin
          tag_pipe_reg[gi] <= tag_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  // Results still in the pipeline when reset hit belong to abandoned issues;
  // they all drain within PIPE_LAT cycles, so ignore the pipeline that long.
  always_ff @(posedge clk) begin
    if (reset) begin
      disc_reg <= DISC_W'(PIPE_LAT);
    end else if (disc_reg != '0) begin
      disc_reg <= disc_reg - DISC_W'(1);
    end
  end

  // ---------------------------------------------------------------- FIFO
  assign push      = encrypt_data_valid && (disc_reg == '0);
  assign out_valid = (wr_ptr_reg != rd_ptr_reg);
  assign pop       = out_valid && out_ready;

  // Small memory with an asynchronous read port: the head must be visible
  // in the same cycle it becomes valid (fall-through).
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {tag_pipe_reg[PIPE_LAT-1], encrypt_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
      end
    end
  end

  assign out_ch   = fifo_mem[rd_ptr_reg[PTR_W-1:0]][65];
  assign out_data = fifo_mem[rd_ptr_reg[PTR_W-1:0]][64:0];

  // ---------------------------------------------------------------- credit
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_reg <= CNT_W'(FIFO_DEPTH);
    end else if (acc && !pop) begin
      credit_reg <= credit_reg - CNT_W'(1);
    end else if (pop && !acc) begin
      credit_reg <= credit_reg + CNT_W'(1);
    end
  end

`ifdef ENC_SCHED_STATS_EN
  // ---------------------------------------------------------------- stats
  logic [31:0] stat_pkt0_reg, stat_pkt1_reg, stat_stall_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_pkt0_reg  <= '0;
      stat_pkt1_reg  <= '0;
      stat_stall_reg <= '0;
    end else begin
      if (acc && acc_data[64] && !cur_ch) begin
        stat_pkt0_reg <= stat_pkt0_reg + 32'd1;
      end
      if (acc && acc_data[64] && cur_ch) begin
        stat_pkt1_reg <= stat_pkt1_reg + 32'd1;
      end
      if (!credit_ok && (in_valid != 2'b00)) begin
        stat_stall_reg <= stat_stall_reg + 32'd1;
      end
    end
  end

  assign stat_pkt0  = stat_pkt0_reg;
  assign stat_pkt1  = stat_pkt1_reg;
  assign stat_stall = stat_stall_reg;
`endif

endmodule

// File: tb/tb_encrypt_sched.sv
// tb_encrypt_sched -- scoreboard bench for encrypt_sched.
// Drivers push the expected result of each accepted beat into a queue; a
// monitor on the falling edge pops and compares every beat the DUT delivers.
// The attached pipeline is modelled as data ^ key with a valid delay of
// PIPE_LAT-1 cycles after compute_resq; it is deliberately not reset.

module tb_encrypt_sched;

  localparam int PIPE_LAT   = 5;
  localparam int FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in0_valid, in1_valid;
  logic [64:0] in0_data, in1_data;
  logic        in0_ready, in1_ready;
  logic        key_wr, key_sel;
  logic [63:0] key_wdata;
  logic        compute_resq;
  logic [64:0] clr_data;
  logic [63:0] key;
  logic [64:0] encrypt_data;
  logic        encrypt_data_valid;
  logic        out_valid;
  logic [64:0] out_data;
  logic        out_ch;
  logic        out_ready;

  encrypt_sched #(.PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .key_wr(key_wr), .key_sel(key_sel), .key_wdata(key_wdata),
    .compute_resq(compute_resq), .clr_data(clr_data), .key(key),
    .encrypt_data(encrypt_data), .encrypt_data_valid(encrypt_data_valid),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ch;
    logic [64:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  logic grant_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_total = 0;
  int   resq_cnt  = 0;
  bit   lat_chk   = 0;
  bit   in_pkt    = 0;
  logic pkt_ch    = 1'b0;
  logic pipe_init;

  always @(posedge clk) cyc <= cyc + 1;

  // Encryption pipeline model
  logic [65:0] pipe [PIPE_LAT-1];
  always @(posedge clk) begin
    if (pipe_init) begin
      for (int i = 0; i < PIPE_LAT-1; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {compute_resq, clr_data[64], clr_data[63:0] ^ key};
      for (int i = 1; i < PIPE_LAT-1; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign encrypt_data_valid = pipe[PIPE_LAT-2][65];
  assign encrypt_data       = pipe[PIPE_LAT-2][64:0];

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic note_accept(input logic ch, input logic last);
    acc_total++;
    if (!in_pkt) begin
      grant_q.push_back(ch);
      pkt_ch = ch;
      in_pkt = 1;
    end else begin
      check("no_interleave", {65'd0, ch}, {65'd0, pkt_ch});
    end
    if (last) in_pkt = 0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (in0_valid && in0_ready) note_accept(1'b0, in0_data[64]);
      if (in1_valid && in1_ready) note_accept(1'b1, in1_data[64]);
      if (compute_resq) resq_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: actual ch=%0d data=%h required none", out_ch, out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_beat", {out_ch, out_data}, {e.ch, e.data});
          $display("beat ch=%0d data=%h cyc=%0d", out_ch, out_data, cyc);
          if (lat_chk) check("latency", 66'(cyc), 66'(e.cyc + 1 + PIPE_LAT));
        end
      end
    end
  end

  // Send one packet; key write (if kw_beat >= 0) coincides with that beat's accept
  task automatic send_pkt(input logic ch, input int nbeats, input logic [63:0] base,
                          input logic [63:0] k, input int kw_beat, input logic [63:0] kw_val);
    logic [64:0] d;
    int w;
    bit got;
    for (int i = 0; i < nbeats; i++) begin
      d = {(i == nbeats-1), base + 64'(i)};
      if (ch) begin in1_valid = 1'b1; in1_data = d; end
      else    begin in0_valid = 1'b1; in0_data = d; end
      w = 0;
      got = 0;
      while (!got) begin
        @(negedge clk);
        if (ch ? in1_ready : in0_ready) begin
          got = 1;
          exp_q.push_back('{ch, {d[64], d[63:0] ^ k}, cyc});
          if (i == kw_beat) begin
            key_wr = 1'b1; key_sel = ch; key_wdata = kw_val;
          end
        end else if (++w > 1000) begin
          n_checks++;
          n_fail++;
          $display("FAIL accept_timeout: actual no ready on ch%0d beat %0d required accept", ch, i);
          if (ch) in1_valid = 1'b0; else in0_valid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
      key_wr = 1'b0;
    end
    if (ch) in1_valid = 1'b0; else in0_valid = 1'b0;
  endtask

  task automatic write_key(input logic sel, input logic [63:0] val);
    key_wr = 1'b1; key_sel = sel; key_wdata = val;
    @(posedge clk);
    #1;
    key_wr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    grant_q.delete();
    in_pkt = 0;
    acc_total = 0;
    resq_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 1000) begin
      @(posedge clk);
      w++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("drain", 66'(exp_q.size()), 66'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    reset = 1'b1; pipe_init = 1'b1;
    in0_valid = 0; in1_valid = 0; in0_data = '0; in1_data = '0;
    key_wr = 0; key_sel = 0; key_wdata = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pipe_init = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in0_ready", {65'd0, in0_ready}, 66'd0);
    check("rst_in1_ready", {65'd0, in1_ready}, 66'd0);
    check("rst_out_valid", {65'd0, out_valid}, 66'd0);
    check("rst_compute_resq", {65'd0, compute_resq}, 66'd0);
    check("rst_clr_data", {1'b0, clr_data}, 66'd0);
    check("rst_key", {2'b0, key}, 66'd0);
    @(posedge clk);
    #1;

    // ch0 3-beat packet, key 1, exact latency
    write_key(1'b0, 64'h1);
    lat_chk = 1;
    send_pkt(1'b0, 3, 64'h100, 64'h1, -1, '0);
    wait_drain();
    lat_chk = 0;
    check("t1_accepts", 66'(acc_total), 66'd3);
    check("t1_resq_count", 66'(resq_cnt), 66'(acc_total));

    // both channels contending, 2-beat packets
    do_reset();
    write_key(1'b0, 64'h3);
    write_key(1'b1, 64'h4);
    fork
      begin
        send_pkt(1'b0, 2, 64'h200, 64'h3, -1, '0);
        send_pkt(1'b0, 2, 64'h210, 64'h3, -1, '0);
      end
      begin
        send_pkt(1'b1, 2, 64'h300, 64'h4, -1, '0);
        send_pkt(1'b1, 2, 64'h310, 64'h4, -1, '0);
      end
    join
    wait_drain();
    check("t2_grants", 66'(grant_q.size()), 66'd4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      check("t2_grant_order", {65'd0, grant_q[i]}, 66'(i % 2));

    // credit exhaustion with out_ready low
    a0 = acc_total;
    out_ready = 1'b0;
    fork
      send_pkt(1'b1, 12, 64'h400, 64'h4, -1, '0);
      begin
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("t3_accept_8", 66'(acc_total - a0), 66'(FIFO_DEPTH));
        check("t3_in1_ready_low", {65'd0, in1_ready}, 66'd0);
        check("t3_out_valid", {65'd0, out_valid}, 66'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t3_accept_one_more", 66'(acc_total - a0), 66'(FIFO_DEPTH + 1));
        check("t3_in1_ready_low2", {65'd0, in1_ready}, 66'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("t3_resq_count", 66'(resq_cnt), 66'(acc_total));

    // key writes: mid-packet, then same cycle as the first-beat snapshot
    write_key(1'b0, 64'h5);
    send_pkt(1'b0, 3, 64'h500, 64'h5, 1, 64'hA);
    send_pkt(1'b0, 2, 64'h600, 64'hA, -1, '0);
    send_pkt(1'b0, 2, 64'h700, 64'hA, 0, 64'hC);
    send_pkt(1'b0, 1, 64'h800, 64'hC, -1, '0);
    wait_drain();

    // reset with 3 beats in flight
    write_key(1'b1, 64'h7);
    send_pkt(1'b1, 3, 64'h900, 64'h7, -1, '0);
    do_reset();
    for (int i = 0; i < PIPE_LAT + 3; i++) begin
      @(negedge clk);
      check("t5_no_late_result", {65'd0, out_valid}, 66'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    fork
      send_pkt(1'b0, 10, 64'hA00, 64'h0, -1, '0);
      begin
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("t5_credit_after_reset", 66'(acc_total), 66'(FIFO_DEPTH));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("t5_resq_count", 66'(resq_cnt), 66'(acc_total));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
